// File: rtl/axis_ola_16x8_v1.sv
// 16-channel to 8-lane 50%-overlap-add synthesis stage: add, scale, saturate, 2-stage pipeline.
// Optional build macro OLA_ROUND_EN selects round-half-up before the shift (default: floor).
module axis_ola_16x8_v1 (
  input  logic         aclk,
  input  logic         aresetn,
  output logic         s_axis_tready,
  input  logic         s_axis_tvalid,
  input  logic [511:0] s_axis_tdata,
  input  logic         s_axis_tsync,
  input  logic         m_axis_tready,
  output logic         m_axis_tvalid,
  output logic [255:0] m_axis_tdata,
  input  logic [1:0]   qout,
  input  logic         sat_clr,
  output logic [15:0]  sat_cnt
);
  localparam int N = 16;
  localparam int L = 8;
  localparam int B = 16;
  localparam int C = 2 * L;  // I/Q components per output beat

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic                 rdy_reg;
  logic [0:0]           state_reg;
  logic [N*B-1:0]       hist_reg;
  logic                 s1_valid_reg;
  logic signed [B:0]    s1_sum_reg [C];
  logic [1:0]           s1_q_reg;
  logic                 m_valid_reg;
  logic [L*2*B-1:0]     m_data_reg;
  logic [15:0]          sat_cnt_reg;

  logic signed [B:0]    sum_next [C];
  logic [C-1:0]         sat_flag;
  logic [L*2*B-1:0]     y_bus;
  logic [4:0]           sat_beat;
  logic [16:0]          sat_sum;
  logic                 stall;
  logic                 accept;
  logic                 use_hist;

  // Scale a 17-bit sum by q and clamp to 16 bits; MSB of the result flags a clamp.
  function automatic logic [16:0] scale_sat(input logic signed [16:0] s, input logic [1:0] q);
    logic signed [17:0] t;
    t = {s[16], s};
`ifdef OLA_ROUND_EN
    case (q)
      2'd1:    t = t + 18'sd1;
      2'd2:    t = t + 18'sd2;
      2'd3:    t = t + 18'sd4;
      default: t = t;
    endcase
`endif
    t = t >>> q;
    if (t > 18'sd32767)
      return {1'b1, 16'h7fff};
    if (t < -18'sd32768)
      return {1'b1, 16'h8000};
    return {1'b0, t[15:0]};
  endfunction

  assign stall         = m_valid_reg && !m_axis_tready;
  assign s_axis_tready = rdy_reg && !stall;
  assign accept        = s_axis_tvalid && s_axis_tready;
  // A resync beat starts a fresh overlap chain, exactly like the first beat after EMPTY.
  assign use_hist      = (state_reg == ST_RUN) && !s_axis_tsync;

  // Component gi (lane gi/2, I or Q) sits at bit 16*gi in both the frame and the history.
  genvar gi;
  generate
    for (gi = 0; gi < C; gi++) begin : g_comp
      assign sum_next[gi] = $signed({s_axis_tdata[B*gi+B-1], s_axis_tdata[B*gi +: B]}) +
                            (use_hist ? $signed({hist_reg[B*gi+B-1], hist_reg[B*gi +: B]})
                                      : 17'sd0);
      assign {sat_flag[gi], y_bus[B*gi +: B]} = scale_sat(s1_sum_reg[gi], s1_q_reg);
    end
  endgenerate

  always_comb begin
    sat_beat = 5'd0;
    for (int i = 0; i < C; i++)
      sat_beat = sat_beat + {4'd0, sat_flag[i]};
    sat_sum = {1'b0, sat_cnt_reg} + {12'd0, sat_beat};
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rdy_reg      <= 1'b0;
      state_reg    <= ST_EMPTY;
      hist_reg     <= '0;
      s1_valid_reg <= 1'b0;
      s1_q_reg     <= 2'd0;
      for (int i = 0; i < C; i++)
        s1_sum_reg[i] <= '0;
      m_valid_reg  <= 1'b0;
      m_data_reg   <= '0;
      sat_cnt_reg  <= 16'd0;
    end else begin
      rdy_reg <= 1'b1;
      if (!stall) begin
        s1_valid_reg <= accept;
        if (accept) begin
          for (int i = 0; i < C; i++)
            s1_sum_reg[i] <= sum_next[i];
          s1_q_reg <= qout;
        end
        m_valid_reg <= s1_valid_reg;
        if (s1_valid_reg)
          m_data_reg <= y_bus;
      end
      if (accept) begin
        hist_reg  <= s_axis_tdata[N*2*B-1 -: N*B];
        state_reg <= ST_RUN;
      end else if (s_axis_tsync) begin
        hist_reg  <= '0;
        state_reg <= ST_EMPTY;
      end
      // Clear takes priority over a same-cycle increment.
      if (sat_clr)
        sat_cnt_reg <= 16'd0;
      else if (!stall && s1_valid_reg)
        sat_cnt_reg <= sat_sum[16] ? 16'hffff : sat_sum[15:0];
    end
  end

  assign m_axis_tvalid = m_valid_reg;
  assign m_axis_tdata  = m_data_reg;
  assign sat_cnt       = sat_cnt_reg;
endmodule

// File: tb/tb_axis_ola_16x8_v1.sv
// Directed bench for axis_ola_16x8_v1: queue-based overlap-add model plus literal spot checks.
module tb_axis_ola_16x8_v1;
  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic         s_tready;
  logic         s_tvalid = 1'b0;
  logic [511:0] s_tdata = '0;
  logic         s_tsync = 1'b0;
  logic         m_ready = 1'b1;
  logic         m_valid;
  logic [255:0] m_tdata;
  logic [1:0]   qout = 2'd0;
  logic         sat_clr = 1'b0;
  logic [15:0]  sat_cnt;

  int checks = 0;
  int errors = 0;

  logic [255:0] exp_q[$];
  int           exp_sat[$];
  int           mh_i[8];
  int           mh_q[8];
  int           sat_model = 0;
  bit           sat_chk_en = 1'b1;
  int           n_out = 0;
  logic [255:0] last_out = '0;
  logic [255:0] mon_e;
  int           mon_ns;
  int           mon_ai, mon_aq, mon_hi, mon_hq;
  bit           mon_f1, mon_f2;

  axis_ola_16x8_v1 dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tready(s_tready), .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata),
    .s_axis_tsync(s_tsync), .m_axis_tready(m_ready), .m_axis_tvalid(m_valid),
    .m_axis_tdata(m_tdata), .qout(qout), .sat_clr(sat_clr), .sat_cnt(sat_cnt)
  );

  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Plain-integer view of one output component.
  function automatic logic [15:0] ola(input int s, input int q, output bit sat);
    int y;
    y = s;
`ifdef OLA_ROUND_EN
    if (q > 0) y = y + (1 << (q - 1));
`endif
    y = y >>> q;
    sat = 1'b0;
    if (y > 32767) begin y = 32767; sat = 1'b1; end
    else if (y < -32768) begin y = -32768; sat = 1'b1; end
    return 16'(y);
  endfunction

  // Compare outputs, then advance the model with whatever the upcoming edge accepts.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (m_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat act=%h exp=none", m_tdata);
        end else begin
          if (m_tdata !== exp_q[0]) begin
            errors++;
            $display("FAIL beat_data act=%h exp=%h", m_tdata, exp_q[0]);
          end
          if (m_ready) begin
            sat_model = sat_model + exp_sat[0];
            if (sat_model > 65535) sat_model = 65535;
            void'(exp_q.pop_front());
            void'(exp_sat.pop_front());
            n_out++;
            last_out = m_tdata;
            if (sat_chk_en) begin
              checks++;
              if (sat_cnt !== 16'(sat_model)) begin
                errors++;
                $display("FAIL sat_cnt_stream act=%0d exp=%0d", sat_cnt, sat_model);
              end
            end
          end
        end
      end
      if (s_tvalid && s_tready) begin
        mon_ns = 0;
        for (int j = 0; j < 8; j++) begin
          mon_ai = $signed(s_tdata[32*j +: 16]);
          mon_aq = $signed(s_tdata[32*j+16 +: 16]);
          mon_hi = s_tsync ? 0 : mh_i[j];
          mon_hq = s_tsync ? 0 : mh_q[j];
          mon_e[32*j +: 16]    = ola(mon_ai + mon_hi, int'(qout), mon_f1);
          mon_e[32*j+16 +: 16] = ola(mon_aq + mon_hq, int'(qout), mon_f2);
          mon_ns = mon_ns + int'(mon_f1) + int'(mon_f2);
        end
        for (int j = 0; j < 8; j++) begin
          mh_i[j] = $signed(s_tdata[256+32*j +: 16]);
          mh_q[j] = $signed(s_tdata[256+32*j+16 +: 16]);
        end
        exp_q.push_back(mon_e);
        exp_sat.push_back(mon_ns);
      end else if (s_tsync) begin
        for (int j = 0; j < 8; j++) begin mh_i[j] = 0; mh_q[j] = 0; end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] fill(input int li, input int lq, input int hi, input int hq);
    logic [511:0] f;
    for (int k = 0; k < 8; k++) begin
      f[32*k +: 32]     = {16'(lq), 16'(li)};
      f[256+32*k +: 32] = {16'(hq), 16'(hi)};
    end
    return f;
  endfunction

  // Present one frame; returns #1 after the accepting edge.
  task automatic send(input logic [511:0] f, input logic sy);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    s_tdata = f; s_tsync = sy; s_tvalid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge aclk);
      acc = s_tready;
      @(posedge aclk); #1;
      n++;
    end
    s_tvalid = 1'b0; s_tsync = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout act=%0d exp=accept", n);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      @(posedge aclk);
      n++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain act=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic clear_sat();
    sat_clr = 1'b1;
    @(posedge aclk); #1;
    sat_clr = 1'b0;
    sat_model = 0;
  endtask

  initial begin
    logic [511:0] f;
    logic [511:0] f30;
    int base;
    f30 = fill(30000, 0, 30000, 0);
    for (int j = 0; j < 8; j++) begin mh_i[j] = 0; mh_q[j] = 0; end

    // reset state
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_s_tready", {31'd0, s_tready}, 32'd0);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_tdata", m_tdata[31:0], 32'd0);
    chk("rst_sat_cnt", {16'd0, sat_cnt}, 32'd0);
    @(negedge aclk); aresetn = 1'b1;
    @(posedge aclk); #1;
    chk("post_rst_s_tready", {31'd0, s_tready}, 32'd1);

    // T1: first frame uses empty history; valid one cycle after the S1 capture
    send(fill(100, -100, 100, -100), 1'b0);
    chk("t1_latency_s1", {31'd0, m_valid}, 32'd0);
    @(posedge aclk); #1;
    chk("t1_latency_s2", {31'd0, m_valid}, 32'd1);
    chk("t1_lane0", m_tdata[31:0], 32'hff9c0064);
    chk("t1_lane7", m_tdata[255:224], 32'hff9c0064);
    drain();

    // T2: overlap with previous upper half
    send(fill(1000, 0, 7, 0), 1'b0);
    drain();
    chk("t2_lane0", last_out[31:0], 32'hff9c044c);
    chk("t2_lane5", last_out[191:160], 32'hff9c044c);

    // T3: saturation, then halving removes it
    clear_sat();
    repeat (3) send(f30, 1'b0);
    drain();
    chk("t3_sat_lane", last_out[31:0], 32'h00007fff);
    chk("t3_sat_cnt", {16'd0, sat_cnt}, 32'd16);
    qout = 2'd1;
    repeat (2) send(f30, 1'b0);
    drain();
    chk("t3_q1_lane", last_out[31:0], 32'h00007530);
    chk("t3_q1_sat_cnt", {16'd0, sat_cnt}, 32'd16);

    // T4: sums of +3 and -3 shifted by one
    send(fill(1, 0, 2, -2), 1'b1);
    send(fill(1, -1, 0, 0), 1'b0);
    drain();
`ifdef OLA_ROUND_EN
    chk("t4_round", last_out[31:0], 32'hffff0002);
`else
    chk("t4_floor", last_out[31:0], 32'hfffe0001);
`endif
    qout = 2'd0;

    // T5: downstream stall of 5 cycles while frames keep coming
    base = n_out;
    fork
      begin
        for (int i = 1; i <= 5; i++) begin
          for (int k = 0; k < 16; k++) f[32*k +: 32] = {16'(-i), 16'(10*i + k)};
          send(f, 1'b0);
        end
      end
      begin
        m_ready = 1'b0;
        repeat (5) @(posedge aclk);
        #1;
        chk("t5_stall_tready", {31'd0, s_tready}, 32'd0);
        chk("t5_stall_valid", {31'd0, m_valid}, 32'd1);
        m_ready = 1'b1;
      end
    join
    drain();
    chk("t5_count", 32'(n_out - base), 32'd5);

    // sat_clr on the same edge a saturating beat lands: clear wins
    sat_chk_en = 1'b0;
    send(f30, 1'b0);
    drain();
    send(f30, 1'b0);
    sat_clr = 1'b1;
    @(posedge aclk); #1;
    sat_clr = 1'b0;
    chk("clr_wins_valid", {31'd0, m_valid}, 32'd1);
    chk("clr_wins_cnt", {16'd0, sat_cnt}, 32'd0);
    drain();
    clear_sat();
    sat_chk_en = 1'b1;

    // T6: tsync with a beat ignores history of 500
    send(fill(500, 0, 500, 0), 1'b0);
    for (int k = 0; k < 8; k++) f[32*k +: 32] = {16'(k), 16'(11*(k+1))};
    for (int k = 8; k < 16; k++) f[32*k +: 32] = {16'd0, 16'd9};
    send(f, 1'b1);
    drain();
    chk("t6_sync_lane0", last_out[31:0], 32'h0000000b);
    chk("t6_sync_lane7", last_out[255:224], 32'h00070058);
    // tsync alone empties history
    s_tsync = 1'b1;
    @(posedge aclk); #1;
    s_tsync = 1'b0;
    send(fill(40, 4, 0, 0), 1'b0);
    drain();
    chk("t6_sync_alone", last_out[31:0], 32'h00040028);

    // reset mid-stream
    repeat (3) send(f30, 1'b0);
    #1;
    aresetn = 1'b0;
    #1;
    exp_q.delete(); exp_sat.delete();
    for (int j = 0; j < 8; j++) begin mh_i[j] = 0; mh_q[j] = 0; end
    sat_model = 0;
    chk("midrst_valid", {31'd0, m_valid}, 32'd0);
    chk("midrst_sat_cnt", {16'd0, sat_cnt}, 32'd0);
    chk("midrst_tdata", m_tdata[31:0], 32'd0);
    chk("midrst_tready", {31'd0, s_tready}, 32'd0);
    @(negedge aclk); aresetn = 1'b1;
    @(posedge aclk); #1;
    send(fill(5, 6, 0, 0), 1'b0);
    drain();
    chk("post_midrst_lane0", last_out[31:0], 32'h00060005);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
